read_port_sequencer: RTL and testbench
======================================

// Module: read_port_sequencer
// PURPOSE
//  Sequences the read stage's single memory read port between two requesters: virtual operand reads
//  (read_virtual / read_rmw_virtual) and system reads (read_system_word/dword/qword/descriptor,
//  read_rmw_system_dword). Splits 64-bit system reads into two dword bus reads and assembles read_8.
//  Sits between the read-stage command decode and the memory read channel; absorbs pipeline flushes.
// PARAMETERS
//  ADDR_WIDTH  32  linear address width; qword high-half address = low + 4, modulo 2^ADDR_WIDTH
// PORTS
//  clk             in   1   clock; single clock domain
//  rst             in   1   asynchronous, active-high reset
//  rd_reset        in   1   pipeline flush; cancels any sequence in progress
//  virt_req        in   1   virtual read request level; held with operands until virt_ready/virt_fault
//  virt_rmw        in   1   virtual read is read-modify-write (bus lock)
//  virt_address    in   32  linear address of virtual read
//  virt_length     in   3   bytes: 1, 2 or 4
//  virt_ready      out  1   one-cycle pulse: read_4 valid
//  virt_fault      out  1   one-cycle pulse: bus read faulted
//  sys_req         in   1   system read request level; held until sys_ready/sys_fault
//  sys_rmw         in   1   system dword read is read-modify-write
//  sys_qword       in   1   64-bit read (qword/descriptor)
//  sys_address     in   32  linear address of system read
//  sys_length      in   3   bytes: 2 or 4 (ignored when sys_qword)
//  sys_ready       out  1   one-cycle pulse: read_8 valid
//  sys_fault       out  1   one-cycle pulse: bus read faulted
//  read_4          out  32  virtual read data, zero-extended from length
//  read_8          out  64  system read data; {hi,lo} for qword, zero-extended otherwise
//  mem_read_do     out  1   bus read request; held until mem_read_done or mem_read_fault
//  mem_read_addr   out  32  bus address
//  mem_read_length out  3   bus length in bytes
//  mem_read_lock   out  1   rmw lock qualifier
//  mem_read_system out  1   supervisor (system) access qualifier
//  mem_read_done   in   1   one-cycle pulse: mem_read_data valid, request retired
//  mem_read_fault  in   1   one-cycle pulse: request retired with fault
//  mem_read_data   in   32  bus read data
//  busy            out  1   high in any state other than IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, last_grant = virtual (so first tie goes to system).
//  - States: IDLE, LO (bus read #1 outstanding), HI (qword second half), DRAIN (flushed, bus busy).
//  - IDLE: if any req and !rd_reset -> arbitrate, register addr/len/lock/system, assert mem_read_do
//    next cycle (1-cycle request-to-bus latency). Both pending: grant != last_grant (round-robin).
//  - LO: on mem_read_done: non-qword -> latch data, drop mem_read_do, pulse ready next cycle, IDLE;
//    qword -> latch lo, addr += 4 (wraps), length 4, -> HI with mem_read_do held high.
//  - HI: on mem_read_done -> read_8 = {data, lo}, pulse sys_ready next cycle, IDLE.
//  - mem_read_fault in LO/HI: drop mem_read_do, pulse owner's fault next cycle, IDLE; no HI issued
//    after a LO fault; read_4/read_8 unchanged.
//  - done and fault same cycle: fault wins.
//  - rd_reset in LO/HI: -> DRAIN, no ready/fault pulse; mem_read_do stays high until done/fault
//    (bus request is never withdrawn mid-flight). DRAIN -> IDLE on done/fault, data discarded.
//  - rd_reset in IDLE: no grant that cycle. rd_reset same cycle as done: flush wins, no pulse.
//  - Pulses never overlap a new grant: IDLE re-arbitrates only the cycle after a ready/fault pulse,
//    so a requester dropping req on its pulse is never re-granted.
//  - Zero-extension: length 1 -> data[7:0], 2 -> data[15:0]; length values 0,3,5-7 treated as 4.
//  - rst asserted mid-sequence: immediate IDLE, mem_read_do low (bus side also reset).
// STRUCTURE
//  - Shared package: state encoding constants, length codes (LEN_BYTE/WORD/DWORD), grant IDs.
//  - One natural sub-module: read_port_rr_arbiter (2-way round-robin, last_grant register).
//  - Remainder: FSM, address/length/qualifier registers, lo-half register, output data regs.
// TESTING
//  - virt_req len 2 addr 0x1000, done data 0xDEADBEEF -> mem_read_do cycle 1, read_4=0x0000BEEF, virt_ready 1 pulse.
//  - sys qword addr 0xFFFFFFFC, data 0x11111111 then 0x22222222 -> 2nd addr 0x00000000, read_8=0x2222222211111111.
//  - Both req held continuously, 4 completions -> grants sys, virt, sys, virt.
//  - qword, fault on LO -> sys_fault pulse, no second bus read, read_8 unchanged.
//  - rd_reset during HI, done 3 cycles later -> mem_read_do held till done, no pulses, busy low after.
//  - sys_rmw dword -> mem_read_lock=1, mem_read_system=1; fault+done same cycle -> sys_fault only.

Source files
------------

// File: rtl/read_port_sequencer_pkg.sv
// Shared definitions for the read-port sequencer.
//   state_t      : sequencer states (also exported on the debug port)
//   grant_t      : requester identities used by the arbiter and owner register
//   LEN_*        : bus length codes in bytes
//   norm_length  : folds unsupported length codes onto a dword
//   zero_extend  : trims bus data to the requested length
package read_port_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // nothing outstanding
    ST_LO    = 2'd1,  // first (or only) bus read outstanding
    ST_HI    = 2'd2,  // second half of a qword outstanding
    ST_DRAIN = 2'd3   // flushed, waiting for the bus to retire the read
  } state_t;

  typedef enum logic {
    GRANT_VIRT = 1'b0,
    GRANT_SYS  = 1'b1
  } grant_t;

  localparam logic [2:0] LEN_BYTE  = 3'd1;
  localparam logic [2:0] LEN_WORD  = 3'd2;
  localparam logic [2:0] LEN_DWORD = 3'd4;

  function automatic logic [2:0] norm_length(input logic [2:0] len);
    case (len)
      LEN_BYTE: norm_length = LEN_BYTE;
      LEN_WORD: norm_length = LEN_WORD;
      default:  norm_length = LEN_DWORD;
    endcase
  endfunction

  function automatic logic [31:0] zero_extend(input logic [31:0] data, input logic [2:0] len);
    case (len)
      LEN_BYTE: zero_extend = {24'd0, data[7:0]};
      LEN_WORD: zero_extend = {16'd0, data[15:0]};
      default:  zero_extend = data;
    endcase
  endfunction

endpackage

// File: rtl/read_port_sequencer_if.sv
// Memory read channel between the sequencer (master) and the bus (slave).
// Handshake: the master raises mem_read_do with addr/length/lock/system stable
// and keeps it high until the slave retires the request with a one-cycle
// mem_read_done (mem_read_data valid in that cycle) or mem_read_fault pulse.
// A request is never withdrawn before it is retired.
interface read_port_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_read_do;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [2:0]            mem_read_length;
  logic                  mem_read_lock;
  logic                  mem_read_system;
  logic                  mem_read_done;
  logic                  mem_read_fault;
  logic [31:0]           mem_read_data;

  modport master (
    output mem_read_do, mem_read_addr, mem_read_length, mem_read_lock, mem_read_system,
    input  mem_read_done, mem_read_fault, mem_read_data
  );

  modport slave (
    input  mem_read_do, mem_read_addr, mem_read_length, mem_read_lock, mem_read_system,
    output mem_read_done, mem_read_fault, mem_read_data
  );
endinterface

// File: rtl/read_port_rr_arbiter.sv
// Two-way round-robin arbiter between the virtual and system requesters.
// Ports: virt_req/sys_req request levels, take = grant accepted this cycle,
// grant_valid/grant_id = combinational winner. last_grant resets to virtual
// so the first tie goes to the system requester.
module read_port_rr_arbiter
  import read_port_sequencer_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   virt_req,
  input  logic   sys_req,
  input  logic   take,
  output logic   grant_valid,
  output grant_t grant_id
);
  grant_t last_grant;

  always_comb begin
    grant_valid = virt_req | sys_req;
    grant_id    = GRANT_VIRT;
    if (virt_req && sys_req)
      grant_id = (last_grant == GRANT_VIRT) ? GRANT_SYS : GRANT_VIRT;
    else if (sys_req)
      grant_id = GRANT_SYS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= GRANT_VIRT;
    else if (take && grant_valid)
      last_grant <= grant_id;
  end
endmodule

// File: rtl/read_port_sequencer.sv
// Sequences the read stage's single memory read port between virtual operand
// reads and system reads. 64-bit system reads become two dword bus reads
// (low at addr, high at addr+4 with wrap); results are zero-extended.
// Ports: clk/rst, rd_reset (pipeline flush), virt_* and sys_* request sides
// (request levels in, one-cycle ready/fault pulses out), read_4/read_8 data,
// mem (bus master modport), busy (not idle), dbg_state (current state).
module read_port_sequencer
  import read_port_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_reset,
  input  logic                  virt_req,
  input  logic                  virt_rmw,
  input  logic [ADDR_WIDTH-1:0] virt_address,
  input  logic [2:0]            virt_length,
  output logic                  virt_ready,
  output logic                  virt_fault,
  input  logic                  sys_req,
  input  logic                  sys_rmw,
  input  logic                  sys_qword,
  input  logic [ADDR_WIDTH-1:0] sys_address,
  input  logic [2:0]            sys_length,
  output logic                  sys_ready,
  output logic                  sys_fault,
  output logic [31:0]           read_4,
  output logic [63:0]           read_8,
  read_port_sequencer_if.master mem,
  output logic                  busy,
  output state_t                dbg_state
);
  state_t state_q, state_d;
  grant_t owner_q;
  logic   qword_q;
  logic [31:0] lo_q;

  logic   grant_valid;
  grant_t grant_id;
  logic   take, issue_hi, complete, fault_ev, retire, pulse_active;

  // Holding off arbitration during a pulse cycle keeps a requester that drops
  // its request on the pulse from being granted a second time.
  assign pulse_active = virt_ready | virt_fault | sys_ready | sys_fault;

  read_port_rr_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .virt_req    (virt_req),
    .sys_req     (sys_req),
    .take        (take),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    issue_hi = 1'b0;
    complete = 1'b0;
    fault_ev = 1'b0;
    retire   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rd_reset && !pulse_active && grant_valid) begin
          take    = 1'b1;
          state_d = ST_LO;
        end
      end
      ST_LO, ST_HI: begin
        if (rd_reset) begin
          // A read retired in the flush cycle needs no drain.
          if (mem.mem_read_done || mem.mem_read_fault) begin
            retire  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (mem.mem_read_fault) begin
          fault_ev = 1'b1;
          retire   = 1'b1;
          state_d  = ST_IDLE;
        end else if (mem.mem_read_done) begin
          if (state_q == ST_LO && qword_q) begin
            issue_hi = 1'b1;
            state_d  = ST_HI;
          end else begin
            complete = 1'b1;
            retire   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (mem.mem_read_done || mem.mem_read_fault) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q             <= GRANT_VIRT;
      qword_q             <= 1'b0;
      lo_q                <= '0;
      virt_ready          <= 1'b0;
      virt_fault          <= 1'b0;
      sys_ready           <= 1'b0;
      sys_fault           <= 1'b0;
      read_4              <= '0;
      read_8              <= '0;
      mem.mem_read_do     <= 1'b0;
      mem.mem_read_addr   <= '0;
      mem.mem_read_length <= '0;
      mem.mem_read_lock   <= 1'b0;
      mem.mem_read_system <= 1'b0;
    end else begin
      virt_ready <= 1'b0;
      virt_fault <= 1'b0;
      sys_ready  <= 1'b0;
      sys_fault  <= 1'b0;

      if (take) begin
        owner_q         <= grant_id;
        mem.mem_read_do <= 1'b1;
        if (grant_id == GRANT_SYS) begin
          qword_q             <= sys_qword;
          mem.mem_read_addr   <= sys_address;
          mem.mem_read_length <= sys_qword ? LEN_DWORD : norm_length(sys_length);
          mem.mem_read_lock   <= sys_rmw && !sys_qword;
          mem.mem_read_system <= 1'b1;
        end else begin
          qword_q             <= 1'b0;
          mem.mem_read_addr   <= virt_address;
          mem.mem_read_length <= norm_length(virt_length);
          mem.mem_read_lock   <= virt_rmw;
          mem.mem_read_system <= 1'b0;
        end
      end

      // mem_read_do stays high: the high half is a fresh request next cycle.
      if (issue_hi) begin
        lo_q                <= mem.mem_read_data;
        mem.mem_read_addr   <= mem.mem_read_addr + ADDR_WIDTH'(4);
        mem.mem_read_length <= LEN_DWORD;
      end

      if (retire)
        mem.mem_read_do <= 1'b0;

      if (complete) begin
        if (owner_q == GRANT_SYS) begin
          sys_ready <= 1'b1;
          if (state_q == ST_HI)
            read_8 <= {mem.mem_read_data, lo_q};
          else
            read_8 <= {32'd0, zero_extend(mem.mem_read_data, mem.mem_read_length)};
        end else begin
          virt_ready <= 1'b1;
          read_4     <= zero_extend(mem.mem_read_data, mem.mem_read_length);
        end
      end

      if (fault_ev) begin
        if (owner_q == GRANT_SYS) sys_fault  <= 1'b1;
        else                      virt_fault <= 1'b1;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_read_port_sequencer.sv
module tb_read_port_sequencer;
  import read_port_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd_reset;
  logic        virt_req, virt_rmw, virt_ready, virt_fault;
  logic [31:0] virt_address;
  logic [2:0]  virt_length;
  logic        sys_req, sys_rmw, sys_qword, sys_ready, sys_fault;
  logic [31:0] sys_address;
  logic [2:0]  sys_length;
  logic [31:0] read_4;
  logic [63:0] read_8;
  logic        busy;
  state_t      dbg_state;

  read_port_sequencer_if #(.ADDR_WIDTH(32)) mem_if ();

  read_port_sequencer #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rd_reset(rd_reset),
    .virt_req(virt_req), .virt_rmw(virt_rmw), .virt_address(virt_address),
    .virt_length(virt_length), .virt_ready(virt_ready), .virt_fault(virt_fault),
    .sys_req(sys_req), .sys_rmw(sys_rmw), .sys_qword(sys_qword),
    .sys_address(sys_address), .sys_length(sys_length),
    .sys_ready(sys_ready), .sys_fault(sys_fault),
    .read_4(read_4), .read_8(read_8), .mem(mem_if.master),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_read_4 = '0;
  logic [63:0] exp_read_8 = '0;
  logic [0:0]  exp_q[$];   // expected grant owners (1 = system)

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference rules: byte/word keep the low bytes, every other code is a dword.
  function automatic logic [31:0] mask_len(input logic [31:0] d, input logic [2:0] len);
    if (len == 3'd1)      return d & 32'h0000_00FF;
    else if (len == 3'd2) return d & 32'h0000_FFFF;
    else                  return d;
  endfunction

  function automatic logic [2:0] bus_len(input logic [2:0] len);
    return (len == 3'd1 || len == 3'd2) ? len : 3'd4;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_done(input logic [31:0] d);
    mem_if.mem_read_done = 1'b1;
    mem_if.mem_read_data = d;
    tick();
    mem_if.mem_read_done = 1'b0;
    mem_if.mem_read_data = $urandom;
  endtask

  task automatic bus_fault(input bit with_done, input logic [31:0] d);
    mem_if.mem_read_fault = 1'b1;
    mem_if.mem_read_done  = with_done;
    mem_if.mem_read_data  = d;
    tick();
    mem_if.mem_read_fault = 1'b0;
    mem_if.mem_read_done  = 1'b0;
  endtask

  task automatic wait_do(input string tag);
    int n;
    n = 0;
    while (!mem_if.mem_read_do && n < 10) begin
      tick();
      n++;
    end
    check(tag, {63'd0, mem_if.mem_read_do}, 64'd1);
  endtask

  task automatic drop_and_idle(input string tag);
    virt_req = 1'b0;
    sys_req  = 1'b0;
    tick();
    check({tag, "_pulse_end"}, {60'd0, virt_ready, virt_fault, sys_ready, sys_fault}, 64'd0);
    check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_idle_do"}, {63'd0, mem_if.mem_read_do}, 64'd0);
  endtask

  // One complete transaction from an idle, pulse-free sequencer.
  // fault_at: 0 none, 1 fault on first bus read, 2 fault on qword high half.
  task automatic xact(input string tag, input bit sys, input bit qw, input bit rmw,
                      input logic [31:0] addr, input logic [2:0] len, input int fault_at,
                      input logic [31:0] d0, input logic [31:0] d1, input bit with_done);
    bit ok;
    if (sys) begin
      sys_req = 1'b1; sys_qword = qw; sys_rmw = rmw; sys_address = addr; sys_length = len;
    end else begin
      virt_req = 1'b1; virt_rmw = rmw; virt_address = addr; virt_length = len;
    end
    tick();
    check({tag, "_do"}, {63'd0, mem_if.mem_read_do}, 64'd1);
    check({tag, "_addr"}, {32'd0, mem_if.mem_read_addr}, {32'd0, addr});
    check({tag, "_len"}, {61'd0, mem_if.mem_read_length}, {61'd0, qw ? 3'd4 : bus_len(len)});
    check({tag, "_lock_sys"}, {62'd0, mem_if.mem_read_lock, mem_if.mem_read_system},
          {62'd0, sys ? (rmw && !qw) : rmw, sys});
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    repeat ($urandom_range(0, 2)) tick();
    if (fault_at == 1) begin
      bus_fault(with_done, d0);
    end else begin
      bus_done(d0);
      if (qw) begin
        check({tag, "_hi_do"}, {63'd0, mem_if.mem_read_do}, 64'd1);
        check({tag, "_hi_addr"}, {32'd0, mem_if.mem_read_addr}, {32'd0, addr + 32'd4});
        check({tag, "_hi_len"}, {61'd0, mem_if.mem_read_length}, 64'd4);
        check({tag, "_hi_nopulse"}, {60'd0, virt_ready, virt_fault, sys_ready, sys_fault}, 64'd0);
        repeat ($urandom_range(0, 2)) tick();
        if (fault_at == 2) bus_fault(with_done, d1);
        else               bus_done(d1);
      end
    end
    ok = (fault_at == 0) || (fault_at == 2 && !qw);
    if (ok) begin
      if (sys) exp_read_8 = qw ? {d1, d0} : {32'd0, mask_len(d0, len)};
      else     exp_read_4 = mask_len(d0, len);
    end
    check({tag, "_pulse"}, {60'd0, virt_ready, virt_fault, sys_ready, sys_fault},
          {60'd0, !sys && ok, !sys && !ok, sys && ok, sys && !ok});
    check({tag, "_done_do"}, {63'd0, mem_if.mem_read_do}, 64'd0);
    check({tag, "_read_4"}, {32'd0, read_4}, {32'd0, exp_read_4});
    check({tag, "_read_8"}, read_8, exp_read_8);
    drop_and_idle(tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (compared=%0d)", compared);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [0:0]  last_owner, owner;
    logic [31:0] d, saved8_lo;
    bit          rs, rq;
    int          fa, r;
    logic [2:0]  ln;

    rst = 1'b1; rd_reset = 1'b0;
    virt_req = 1'b0; virt_rmw = 1'b0; virt_address = '0; virt_length = 3'd4;
    sys_req = 1'b0; sys_rmw = 1'b0; sys_qword = 1'b0; sys_address = '0; sys_length = 3'd4;
    mem_if.mem_read_done = 1'b0; mem_if.mem_read_fault = 1'b0; mem_if.mem_read_data = '0;
    repeat (3) tick();
    check("reset_outputs", {57'd0, virt_ready, virt_fault, sys_ready, sys_fault,
                            mem_if.mem_read_do, mem_if.mem_read_lock, busy}, 64'd0);
    check("reset_read_4", {32'd0, read_4}, 64'd0);
    check("reset_read_8", read_8, 64'd0);
    rst = 1'b0;
    tick();

    // Round robin with both requesters held: first tie goes to system.
    last_owner = 1'b0;
    for (int k = 0; k < 4; k++) begin
      last_owner = ~last_owner;
      exp_q.push_back(last_owner);
    end
    virt_req = 1'b1; virt_address = 32'h2000; virt_length = 3'd4; virt_rmw = 1'b0;
    sys_req = 1'b1; sys_address = 32'h3000; sys_length = 3'd4; sys_qword = 1'b0; sys_rmw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_do("rr_wait_do");
      owner = exp_q.pop_front();
      check("rr_owner", {63'd0, mem_if.mem_read_system}, {63'd0, owner});
      check("rr_addr", {32'd0, mem_if.mem_read_addr}, owner ? 64'h3000 : 64'h2000);
      d = $urandom;
      bus_done(d);
      if (owner) exp_read_8 = {32'd0, d};
      else       exp_read_4 = d;
      check("rr_pulse", {62'd0, virt_ready, sys_ready}, {62'd0, !owner, owner});
      check("rr_read", owner ? read_8 : {32'd0, read_4},
            owner ? exp_read_8 : {32'd0, exp_read_4});
    end
    drop_and_idle("rr");

    xact("virt_word", 1'b0, 1'b0, 1'b0, 32'h0000_1000, 3'd2, 0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xact("qword_wrap", 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 3'd4, 0, 32'h1111_1111, 32'h2222_2222, 1'b0);
    xact("qword_lo_fault", 1'b1, 1'b1, 1'b0, 32'h0000_4000, 3'd4, 1, 32'h3333_3333, 32'h4444_4444, 1'b0);
    xact("rmw_fault_done", 1'b1, 1'b0, 1'b1, 32'h0000_5000, 3'd4, 1, 32'h5555_5555, 32'h0, 1'b1);
    xact("virt_byte_rmw", 1'b0, 1'b0, 1'b1, 32'h0000_5004, 3'd1, 0, 32'hCAFE_F00D, 32'h0, 1'b0);
    xact("virt_len3", 1'b0, 1'b0, 1'b0, 32'h0000_5008, 3'd3, 0, 32'h1234_5678, 32'h0, 1'b0);

    // Flush while the qword high half is outstanding.
    sys_req = 1'b1; sys_qword = 1'b1; sys_rmw = 1'b0; sys_address = 32'h6000;
    tick();
    bus_done(32'hAAAA_0000);
    check("flush_hi_addr", {32'd0, mem_if.mem_read_addr}, 64'h6004);
    rd_reset = 1'b1;
    tick();
    rd_reset = 1'b0; sys_req = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("flush_do_held", {63'd0, mem_if.mem_read_do}, 64'd1);
      check("flush_nopulse", {60'd0, virt_ready, virt_fault, sys_ready, sys_fault}, 64'd0);
    end
    bus_done(32'hBBBB_BBBB);
    check("drain_do", {63'd0, mem_if.mem_read_do}, 64'd0);
    check("drain_busy", {63'd0, busy}, 64'd0);
    check("drain_nopulse", {60'd0, virt_ready, virt_fault, sys_ready, sys_fault}, 64'd0);
    check("drain_read_8", read_8, exp_read_8);
    tick();
    check("drain_nopulse2", {60'd0, virt_ready, virt_fault, sys_ready, sys_fault}, 64'd0);

    // Flush in idle blocks the grant for that cycle.
    virt_req = 1'b1; virt_address = 32'h7000; virt_length = 3'd4; virt_rmw = 1'b0;
    rd_reset = 1'b1;
    tick();
    check("idle_flush_nogrant", {63'd0, mem_if.mem_read_do}, 64'd0);
    rd_reset = 1'b0;
    tick();
    check("idle_flush_grant", {63'd0, mem_if.mem_read_do}, 64'd1);
    // Flush in the same cycle as done: flush wins, no pulse, no drain.
    rd_reset = 1'b1;
    saved8_lo = exp_read_4;
    bus_done(32'h9999_9999);
    rd_reset = 1'b0;
    check("flush_done_do", {63'd0, mem_if.mem_read_do}, 64'd0);
    check("flush_done_busy", {63'd0, busy}, 64'd0);
    check("flush_done_nopulse", {60'd0, virt_ready, virt_fault, sys_ready, sys_fault}, 64'd0);
    check("flush_done_read_4", {32'd0, read_4}, {32'd0, saved8_lo});
    drop_and_idle("flush_done");

    // Randomized transactions.
    for (int k = 0; k < 40; k++) begin
      rs = 1'($urandom_range(0, 1));
      rq = rs ? 1'($urandom_range(0, 1)) : 1'b0;
      ln = rs ? (($urandom_range(0, 1) != 0) ? 3'd2 : 3'd4) : 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      fa = (r < 3) ? (rq ? $urandom_range(1, 2) : 1) : 0;
      xact("rand", rs, rq, 1'($urandom_range(0, 1)), $urandom, ln, fa,
           $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
